// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants, selector enums and the control bundle for the pipelined control unit.
package pipe_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h8;

    localparam int unsigned ALU_OP_BASE_W = 4;
    localparam int unsigned BUNDLE_HDR_W  = 12;

    typedef enum logic [1:0] {
        ASelRs1  = 2'd0,
        ASelPc   = 2'd1,
        ASelZero = 2'd2
    } alu_a_sel_e;

    typedef enum logic {
        BSelRs2 = 1'b0,
        BSelImm = 1'b1
    } alu_b_sel_e;

    typedef enum logic [2:0] {
        ImmI = 3'd0,
        ImmS = 3'd1,
        ImmB = 3'd2,
        ImmU = 3'd3,
        ImmJ = 3'd4
    } imm_sel_e;

    typedef struct packed {
        logic       illegal;
        logic       write;
        logic       store;
        logic       load;
        logic       branch;
        logic       jump;
        alu_a_sel_e alu_a_sel;
        alu_b_sel_e alu_b_sel;
        imm_sel_e   imm_sel;
        logic [3:0] alu_op;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/hazard_detection_unit.sv
// Stall and EX-operand forwarding decisions, purely combinational from the stage registers.
// Forwarding is built only with PIPE_CTRL_FORWARDING_EN; otherwise RAW hazards stall instead.
module hazard_detection_unit #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  use_rs1_id,
    input  logic                  use_rs2_id,
    input  logic                  load_ex,
    input  logic                  write_ex,
    input  logic                  write_mem,
    input  logic                  write_wb,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic [REG_ADDR_W-1:0] rs1_ex,
    input  logic [REG_ADDR_W-1:0] rs2_ex,
    output logic                  hazard,
    output logic [1:0]            forward_a_sel,
    output logic [1:0]            forward_b_sel
);

`ifdef PIPE_CTRL_FORWARDING_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    logic       load_use;
    logic       raw_any;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    function automatic logic hit(input logic [REG_ADDR_W-1:0] rs, input logic wr,
                                 input logic [REG_ADDR_W-1:0] rd);
        return wr && (rd != '0) && (rd == rs);
    endfunction

    always_comb begin
        load_use = load_ex && ((use_rs1_id && hit(rs1_id, 1'b1, rd_ex)) ||
                               (use_rs2_id && hit(rs2_id, 1'b1, rd_ex)));
        raw_any  = (use_rs1_id && (hit(rs1_id, write_ex, rd_ex) || hit(rs1_id, write_mem, rd_mem) ||
                                   hit(rs1_id, write_wb, rd_wb))) ||
                   (use_rs2_id && (hit(rs2_id, write_ex, rd_ex) || hit(rs2_id, write_mem, rd_mem) ||
                                   hit(rs2_id, write_wb, rd_wb)));
        hazard   = load_use || (!FwdEn && raw_any);

        // MEM is the younger producer, so it wins over WB.
        fwd_a = hit(rs1_ex, write_mem, rd_mem) ? 2'b01 :
                hit(rs1_ex, write_wb, rd_wb)   ? 2'b10 : 2'b00;
        fwd_b = hit(rs2_ex, write_mem, rd_mem) ? 2'b01 :
                hit(rs2_ex, write_wb, rd_wb)   ? 2'b10 : 2'b00;
        forward_a_sel = FwdEn ? fwd_a : 2'b00;
        forward_b_sel = FwdEn ? fwd_b : 2'b00;
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32I control decode plus ID/EX, EX/MEM, MEM/WB control registers with stall/flush handling.
// Optional operand forwarding is enabled by defining PIPE_CTRL_FORWARDING_EN.
module pipelined_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_OP_W   = 4,
    localparam int unsigned CTRL_W    = BUNDLE_HDR_W + ALU_OP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode_id,
    input  logic [2:0]            funct3_id,
    input  logic                  funct7b5_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  redirect_ex,
    input  logic                  stall_ext,
    output logic [CTRL_W-1:0]     ctrl_ex,
    output logic [CTRL_W-1:0]     ctrl_mem,
    output logic [CTRL_W-1:0]     ctrl_wb,
    output logic [REG_ADDR_W-1:0] rd_wb,
    output logic                  stall_if_id,
    output logic                  flush_id,
    output logic [1:0]            forward_a_sel,
    output logic [1:0]            forward_b_sel
);

    localparam int unsigned IDX_WRITE = CTRL_W - 2;
    localparam int unsigned IDX_LOAD  = CTRL_W - 4;

    ctrl_bundle_t          dec;
    logic                  use_rs1;
    logic                  use_rs2;
    logic [CTRL_W-1:0]     dec_wide;
    logic [CTRL_W-1:0]     ctrl_ex_q, ctrl_mem_q, ctrl_wb_q;
    logic [REG_ADDR_W-1:0] rd_ex_q, rd_mem_q, rd_wb_q, rs1_ex_q, rs2_ex_q;
    logic                  hazard;
    logic                  advance;
    logic                  bubble_id;

    always_comb begin
        dec     = BUBBLE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode_id)
            OPC_OP: begin
                dec.write  = 1'b1;
                dec.alu_op = {funct7b5_id, funct3_id};
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.write     = 1'b1;
                dec.alu_b_sel = BSelImm;
                dec.alu_op    = {(funct3_id == 3'b101) ? funct7b5_id : 1'b0, funct3_id};
                use_rs1       = 1'b1;
            end
            OPC_LOAD: begin
                dec.write     = 1'b1;
                dec.load      = 1'b1;
                dec.alu_b_sel = BSelImm;
                use_rs1       = 1'b1;
            end
            OPC_STORE: begin
                dec.store     = 1'b1;
                dec.alu_b_sel = BSelImm;
                dec.imm_sel   = ImmS;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OPC_BRANCH: begin
                dec.branch  = 1'b1;
                dec.imm_sel = ImmB;
                dec.alu_op  = ALU_SUB;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            OPC_JALR: begin
                dec.write     = 1'b1;
                dec.jump      = 1'b1;
                dec.alu_b_sel = BSelImm;
                use_rs1       = 1'b1;
            end
            OPC_JAL: begin
                dec.write     = 1'b1;
                dec.jump      = 1'b1;
                dec.alu_a_sel = ASelPc;
                dec.alu_b_sel = BSelImm;
                dec.imm_sel   = ImmJ;
            end
            OPC_LUI: begin
                dec.write     = 1'b1;
                dec.alu_a_sel = ASelZero;
                dec.alu_b_sel = BSelImm;
                dec.imm_sel   = ImmU;
            end
            OPC_AUIPC: begin
                dec.write     = 1'b1;
                dec.alu_a_sel = ASelPc;
                dec.alu_b_sel = BSelImm;
                dec.imm_sel   = ImmU;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (rd_id == '0) dec.write = 1'b0;
    end

    // Stretch the fixed bundle to CTRL_W; ALU op bits above the base four stay zero.
    always_comb begin
        dec_wide = '0;
        dec_wide[CTRL_W-1 -: BUNDLE_HDR_W] = dec[$bits(ctrl_bundle_t)-1 -: BUNDLE_HDR_W];
        dec_wide[ALU_OP_BASE_W-1:0] = dec.alu_op;
    end

    assign advance   = redirect_ex || !stall_ext;
    assign bubble_id = redirect_ex || (!stall_ext && hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_ex_q  <= '0;
            ctrl_mem_q <= '0;
            ctrl_wb_q  <= '0;
            rd_ex_q    <= '0;
            rd_mem_q   <= '0;
            rd_wb_q    <= '0;
            rs1_ex_q   <= '0;
            rs2_ex_q   <= '0;
        end else if (advance) begin
            ctrl_mem_q <= ctrl_ex_q;
            ctrl_wb_q  <= ctrl_mem_q;
            rd_mem_q   <= rd_ex_q;
            rd_wb_q    <= rd_mem_q;
            if (bubble_id) begin
                ctrl_ex_q <= '0;
                rd_ex_q   <= '0;
                rs1_ex_q  <= '0;
                rs2_ex_q  <= '0;
            end else begin
                ctrl_ex_q <= dec_wide;
                rd_ex_q   <= rd_id;
                // Unused source fields are zeroed so they can never request a forward.
                rs1_ex_q  <= use_rs1 ? rs1_id : '0;
                rs2_ex_q  <= use_rs2 ? rs2_id : '0;
            end
        end
    end

    hazard_detection_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard (
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .use_rs1_id   (use_rs1),
        .use_rs2_id   (use_rs2),
        .load_ex      (ctrl_ex_q[IDX_LOAD]),
        .write_ex     (ctrl_ex_q[IDX_WRITE]),
        .write_mem    (ctrl_mem_q[IDX_WRITE]),
        .write_wb     (ctrl_wb_q[IDX_WRITE]),
        .rd_ex        (rd_ex_q),
        .rd_mem       (rd_mem_q),
        .rd_wb        (rd_wb_q),
        .rs1_ex       (rs1_ex_q),
        .rs2_ex       (rs2_ex_q),
        .hazard       (hazard),
        .forward_a_sel(forward_a_sel),
        .forward_b_sel(forward_b_sel)
    );

    assign ctrl_ex     = ctrl_ex_q;
    assign ctrl_mem    = ctrl_mem_q;
    assign ctrl_wb     = ctrl_wb_q;
    assign rd_wb       = rd_wb_q;
    assign flush_id    = !rst && redirect_ex;
    assign stall_if_id = !rst && !redirect_ex && (stall_ext || hazard);

endmodule
